// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

    localparam int MD_WIDTH   = 32;
    localparam int MD_LATENCY = MD_WIDTH + 1;

    typedef enum logic [1:0] {
        MULT  = 2'b00,
        MULTU = 2'b01,
        DIV   = 2'b10,
        DIVU  = 2'b11
    } t_mdop;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } t_mdstate;

    function automatic logic md_is_signed(input t_mdop o);
        return (o == MULT) || (o == DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on {acc, low}.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] low,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] low_n
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             fits;

    always_comb begin
        sum     = {1'b0, acc} + (low[0] ? {1'b0, mcand} : '0);
        shifted = {acc, low[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, mcand};
        // remainder stays below the divisor, so a non-borrow diff fits WIDTH
        fits    = (diff[WIDTH+1:WIDTH] == 2'b00);
        if (is_div) begin
            acc_n = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            low_n = {low[WIDTH-2:0], fits};
        end else begin
            acc_n = sum[WIDTH:1];
            low_n = {sum[0], low[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO registers.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_FIX  = FIX;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   low;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_n;
    logic [WIDTH-1:0]   low_n;
    logic               sgn;
    logic               new_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        sgn     = md_is_signed(t_mdop'(op));
        new_div = op[1];
        a_neg   = sgn & op_a[WIDTH-1];
        b_neg   = sgn & op_b[WIDTH-1];
        mag_a   = a_neg ? -op_a : op_a;
        mag_b   = b_neg ? -op_b : op_b;
        prod    = neg_q ? -{acc, low} : {acc, low};
    end

    assign busy = (state != S_IDLE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .low    (low),
        .mcand  (mcand),
        .acc_n  (acc_n),
        .low_n  (low_n)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            acc    <= '0;
            low    <= '0;
            mcand  <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_RUN;
                        cnt    <= CW'(WIDTH - 1);
                        is_div <= new_div;
                        neg_q  <= a_neg ^ b_neg;
                        neg_r  <= a_neg;
                        div0   <= (op_b == '0);
                        acc    <= '0;
                        low    <= new_div ? mag_a : mag_b;
                        mcand  <= new_div ? mag_b : mag_a;
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                S_RUN: begin
                    acc <= acc_n;
                    low <= low_n;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) state <= S_FIX;
                end
                S_FIX: begin
                    // divide by zero: remainder sign-fix reproduces op_a in hi
                    if (is_div) begin
                        hi <= neg_r ? -acc : acc;
                        lo <= div0 ? '1 : (neg_q ? -low : low);
                    end else begin
                        {hi, lo} <= prod;
                    end
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
